cr_osf_ob_stage: RTL and testbench

//  Output stage of the OSF egress path, directly downstream of the latency-stamp stage.

---
 rtl/cr_osf_ob_stage_pkg.sv | 28 ++
 rtl/cr_osf_ob_skid.sv | 53 +++++
 rtl/cr_osf_ob_stage.sv | 113 +++++++++++
 tb/tb_cr_osf_ob_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_osf_ob_stage_pkg.sv
// Shared types for the OSF egress output stage.
//   axi4s_dp_bus_t : AXI4-S data-path word (tvalid, tdata, tkeep, tuser, tlast)
//   axi4s_dp_rdy_t : AXI4-S back-pressure (tready)
//   osf_ob_st_e    : TLV framing state
package cr_osf_ob_stage_pkg;

   localparam int         OSF_DATA_W    = 64;
   localparam logic [7:0] OSF_TUSER_SOT = 8'h01;

   typedef enum logic {OSF_OB_IDLE, OSF_OB_FRAME} osf_ob_st_e;

   typedef struct packed {
      logic                    tvalid;
      logic [OSF_DATA_W-1:0]   tdata;
      logic [OSF_DATA_W/8-1:0] tkeep;
      logic [7:0]              tuser;
      logic                    tlast;
   } axi4s_dp_bus_t;

   typedef struct packed {
      logic tready;
   } axi4s_dp_rdy_t;

   function automatic logic is_sot(input logic [7:0] tuser);
      return tuser == OSF_TUSER_SOT;
   endfunction

endpackage

// File: rtl/cr_osf_ob_skid.sv
// Two-entry registered FIFO holding egress words.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write din at the tail
//   pop        : drop the head entry
//   count      : occupancy 0..2
//   head       : oldest entry (meaningful only when count != 0)
// The caller never pushes at count 2 and never pops at count 0.
module cr_osf_ob_skid
   import cr_osf_ob_stage_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  axi4s_dp_bus_t din,
   output logic [1:0]    count,
   output axi4s_dp_bus_t head
);

   axi4s_dp_bus_t ent1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         head  <= '0;
         ent1  <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= din;
               else               ent1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= ent1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged: the new word becomes head when it was
               // the only entry, otherwise it slides in behind ent1.
               if (count == 2'd1) begin
                  head <= din;
               end else begin
                  head <= ent1;
                  ent1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cr_osf_ob_stage.sv
// OSF egress output stage. Pops TLV words from the upstream pipe into a
// 2-entry skid buffer and presents them as AXI4-S to the egress port while
// tracking TLV framing, counting words/frames, and detecting egress stalls.
//   clk, rst_n        : clock, async active-low reset
//   axi4s_in          : upstream word (valid when .tvalid)
//   axi4s_mstr_rd     : pop strobe to upstream
//   axi4s_ob_out      : egress word (registered)
//   axi4s_ob_in       : egress back-pressure (.tready)
//   osf_ob_word_cnt   : egress handshakes, wraps
//   osf_ob_frm_cnt    : completed frames (tlast handshakes), wraps
//   osf_ob_proto_err  : 1-cycle pulse after a framing violation
//   osf_ob_stall      : back-pressure has lasted STALL_LIM cycles
module cr_osf_ob_stage
   import cr_osf_ob_stage_pkg::*;
#(
   parameter int CNT_W     = 32,
   parameter int STALL_LIM = 1024
)(
   input  logic             clk,
   input  logic             rst_n,
   input  axi4s_dp_bus_t    axi4s_in,
   output logic             axi4s_mstr_rd,
   output axi4s_dp_bus_t    axi4s_ob_out,
   input  axi4s_dp_rdy_t    axi4s_ob_in,
   output logic [CNT_W-1:0] osf_ob_word_cnt,
   output logic [CNT_W-1:0] osf_ob_frm_cnt,
   output logic             osf_ob_proto_err,
   output logic             osf_ob_stall
);

   localparam int                 STALL_W   = $clog2(STALL_LIM + 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIM);

   logic               init_done;
   logic [1:0]         count;
   axi4s_dp_bus_t      head;
   logic               hs;
   logic               sot;
   osf_ob_st_e         state;
   logic [STALL_W-1:0] stall_cnt;
   logic [STALL_W-1:0] stall_nxt;

   // Pop depends only on upstream valid and local occupancy; egress tready is
   // deliberately kept out of this path so no comb route crosses the stage.
   assign axi4s_mstr_rd = axi4s_in.tvalid & init_done & (count != 2'd2);

   always_comb begin
      axi4s_ob_out        = head;
      axi4s_ob_out.tvalid = (count != 2'd0);
   end

   assign hs  = axi4s_ob_out.tvalid & axi4s_ob_in.tready;
   assign sot = is_sot(head.tuser);

   cr_osf_ob_skid u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (axi4s_mstr_rd),
      .pop   (hs),
      .din   (axi4s_in),
      .count (count),
      .head  (head)
   );

   always_comb begin
      stall_nxt = '0;
      if (axi4s_ob_out.tvalid && !axi4s_ob_in.tready)
         stall_nxt = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_done        <= 1'b0;
         state            <= OSF_OB_IDLE;
         osf_ob_word_cnt  <= '0;
         osf_ob_frm_cnt   <= '0;
         osf_ob_proto_err <= 1'b0;
         stall_cnt        <= '0;
         osf_ob_stall     <= 1'b0;
      end else begin
         init_done        <= 1'b1;
         osf_ob_proto_err <= 1'b0;
         stall_cnt        <= stall_nxt;
         osf_ob_stall     <= (stall_nxt == STALL_MAX);
         if (hs) begin
            osf_ob_word_cnt <= osf_ob_word_cnt + 1'b1;
            case (state)
               OSF_OB_IDLE: begin
                  // A non-SOT word outside a frame is forwarded but never
                  // closes a frame, even with tlast.
                  if (!sot)
                     osf_ob_proto_err <= 1'b1;
                  else if (head.tlast)
                     osf_ob_frm_cnt <= osf_ob_frm_cnt + 1'b1;
                  else
                     state <= OSF_OB_FRAME;
               end
               OSF_OB_FRAME: begin
                  // SOT inside a frame restarts it; tlast still closes it.
                  if (sot)
                     osf_ob_proto_err <= 1'b1;
                  if (head.tlast) begin
                     osf_ob_frm_cnt <= osf_ob_frm_cnt + 1'b1;
                     state          <= OSF_OB_IDLE;
                  end
               end
               default: state <= OSF_OB_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cr_osf_ob_stage.sv
module tb_cr_osf_ob_stage;
   import cr_osf_ob_stage_pkg::*;

   typedef struct {
      axi4s_dp_bus_t w;
      bit            err;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_n;
   axi4s_dp_bus_t axi4s_in;
   logic          axi4s_mstr_rd;
   axi4s_dp_bus_t axi4s_ob_out;
   axi4s_dp_rdy_t axi4s_ob_in;
   logic [3:0]    osf_ob_word_cnt;
   logic [3:0]    osf_ob_frm_cnt;
   logic          osf_ob_proto_err;
   logic          osf_ob_stall;

   ent_t src[$];
   ent_t expq[$];
   int   checks = 0;
   int   fails  = 0;
   int   seq    = 0;
   int   pops;
   logic [63:0] first_data;

   cr_osf_ob_stage #(.CNT_W(4), .STALL_LIM(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .axi4s_in         (axi4s_in),
      .axi4s_mstr_rd    (axi4s_mstr_rd),
      .axi4s_ob_out     (axi4s_ob_out),
      .axi4s_ob_in      (axi4s_ob_in),
      .osf_ob_word_cnt  (osf_ob_word_cnt),
      .osf_ob_frm_cnt   (osf_ob_frm_cnt),
      .osf_ob_proto_err (osf_ob_proto_err),
      .osf_ob_stall     (osf_ob_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Inputs change just after posedge; outputs are sampled at negedge.
   task automatic cyc_in();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] tuser, input logic tlast, input bit err);
      ent_t e;
      e.w        = '0;
      e.w.tvalid = 1'b1;
      e.w.tdata  = {32'hC0DE_0000, 32'(seq)};
      e.w.tkeep  = 8'(seq * 3 + 1);
      e.w.tuser  = tuser;
      e.w.tlast  = tlast;
      e.err      = err;
      seq++;
      src.push_back(e);
   endtask

   task automatic do_reset();
      cyc_in();
      rst_n = 1'b0;
      src.delete();
      expq.delete();
      axi4s_ob_in.tready = 1'b0;
      repeat (2) cyc_in();
      rst_n = 1'b1;
      cyc_in();
   endtask

   // Upstream pipe model: presents src head, hands it to the scoreboard on pop.
   initial begin
      axi4s_in = '0;
      forever begin
         @(negedge clk);
         if (rst_n && axi4s_mstr_rd && src.size() > 0)
            expq.push_back(src.pop_front());
         @(posedge clk);
         #2;
         if (src.size() > 0) axi4s_in = src[0].w;
         else                axi4s_in = '0;
      end
   end

   // Egress monitor: checks every handshaken word in order and the proto_err pulse.
   initial begin
      bit   pend;
      ent_t e;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend = 1'b0;
         end else begin
            chk("proto_err", 64'(osf_ob_proto_err), 64'(pend));
            pend = 1'b0;
            if (axi4s_ob_out.tvalid && axi4s_ob_in.tready) begin
               if (expq.size() == 0) begin
                  chk("egress_unexpected", 64'd1, 64'd0);
               end else begin
                  e = expq.pop_front();
                  chk("egress_tdata", axi4s_ob_out.tdata, e.w.tdata);
                  chk("egress_ctl", 64'({axi4s_ob_out.tkeep, axi4s_ob_out.tuser, axi4s_ob_out.tlast}),
                      64'({e.w.tkeep, e.w.tuser, e.w.tlast}));
                  pend = e.err;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      axi4s_ob_in.tready = 1'b0;
      repeat (3) smp();
      chk("rst_tvalid", 64'(axi4s_ob_out.tvalid), 64'd0);
      chk("rst_tdata", axi4s_ob_out.tdata, 64'd0);
      chk("rst_word_cnt", 64'(osf_ob_word_cnt), 64'd0);
      chk("rst_frm_cnt", 64'(osf_ob_frm_cnt), 64'd0);
      chk("rst_stall", 64'(osf_ob_stall), 64'd0);
      chk("rst_mstr_rd", 64'(axi4s_mstr_rd), 64'd0);
      cyc_in();
      rst_n = 1'b1;

      // 1: 3-word TLV, no back-pressure
      cyc_in();
      axi4s_ob_in.tready = 1'b1;
      first_data = {32'hC0DE_0000, 32'(seq)};
      push(8'h01, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b0);
      push(8'h00, 1'b1, 1'b0);
      pops = 0;
      for (int i = 0; i < 6; i++) begin
         smp();
         pops += int'(axi4s_mstr_rd);
         if (i == 1) begin
            chk("t1_latency_tvalid", 64'(axi4s_ob_out.tvalid), 64'd1);
            chk("t1_latency_tdata", axi4s_ob_out.tdata, first_data);
         end
      end
      chk("t1_pops", 64'(pops), 64'd3);
      chk("t1_word_cnt", 64'(osf_ob_word_cnt), 64'd3);
      chk("t1_frm_cnt", 64'(osf_ob_frm_cnt), 64'd1);

      // 2: back-pressure fills the buffer, then drain
      do_reset();
      first_data = {32'hC0DE_0000, 32'(seq)};
      for (int i = 0; i < 5; i++) push(8'h01, 1'b1, 1'b0);
      pops = 0;
      for (int i = 0; i < 6; i++) begin
         smp();
         pops += int'(axi4s_mstr_rd);
         if (i >= 1) chk("t2_held_tdata", axi4s_ob_out.tdata, first_data);
      end
      chk("t2_pops", 64'(pops), 64'd2);
      chk("t2_full_no_pop", 64'(axi4s_mstr_rd), 64'd0);
      cyc_in();
      axi4s_ob_in.tready = 1'b1;
      smp();
      chk("t2_drain_cycle_no_pop", 64'(axi4s_mstr_rd), 64'd0);
      smp();
      chk("t2_pop_resumes", 64'(axi4s_mstr_rd), 64'd1);
      repeat (8) smp();
      chk("t2_word_cnt", 64'(osf_ob_word_cnt), 64'd5);
      chk("t2_frm_cnt", 64'(osf_ob_frm_cnt), 64'd5);

      // 3: framing violations
      do_reset();
      axi4s_ob_in.tready = 1'b1;
      push(8'h00, 1'b1, 1'b1);
      repeat (4) smp();
      chk("t3_nosot_frm_cnt", 64'(osf_ob_frm_cnt), 64'd0);
      chk("t3_nosot_word_cnt", 64'(osf_ob_word_cnt), 64'd1);
      cyc_in();
      push(8'h01, 1'b0, 1'b0);
      push(8'h01, 1'b0, 1'b1);
      push(8'h00, 1'b0, 1'b0);
      push(8'h00, 1'b1, 1'b0);
      repeat (4) smp();
      chk("t3_midframe_frm_cnt", 64'(osf_ob_frm_cnt), 64'd0);
      repeat (4) smp();
      chk("t3_frm_cnt", 64'(osf_ob_frm_cnt), 64'd1);
      chk("t3_word_cnt", 64'(osf_ob_word_cnt), 64'd5);

      // 4: stall detection, limit 4
      do_reset();
      push(8'h01, 1'b1, 1'b0);
      smp();
      for (int i = 1; i <= 6; i++) begin
         smp();
         chk($sformatf("t4_stall_c%0d", i), 64'(osf_ob_stall), 64'(i >= 5));
      end
      cyc_in();
      axi4s_ob_in.tready = 1'b1;
      smp();
      chk("t4_stall_hs_cycle", 64'(osf_ob_stall), 64'd1);
      smp();
      chk("t4_stall_cleared", 64'(osf_ob_stall), 64'd0);

      // 5: counter wrap with 4-bit counters
      do_reset();
      axi4s_ob_in.tready = 1'b1;
      for (int i = 0; i < 17; i++) push(8'h01, 1'b1, 1'b0);
      repeat (24) smp();
      chk("t5_word_cnt_wrap", 64'(osf_ob_word_cnt), 64'd1);
      chk("t5_frm_cnt_wrap", 64'(osf_ob_frm_cnt), 64'd1);

      // 6: reset mid-frame with a full buffer
      cyc_in();
      axi4s_ob_in.tready = 1'b0;
      push(8'h01, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b0);
      repeat (3) smp();
      chk("t6_pre_tvalid", 64'(axi4s_ob_out.tvalid), 64'd1);
      chk("t6_pre_full_no_pop", 64'(axi4s_mstr_rd), 64'd0);
      cyc_in();
      rst_n = 1'b0;
      src.delete();
      expq.delete();
      #1;
      chk("t6_rst_tvalid", 64'(axi4s_ob_out.tvalid), 64'd0);
      chk("t6_rst_word_cnt", 64'(osf_ob_word_cnt), 64'd0);
      chk("t6_rst_frm_cnt", 64'(osf_ob_frm_cnt), 64'd0);
      cyc_in();
      push(8'h01, 1'b1, 1'b0);
      axi4s_ob_in.tready = 1'b1;
      cyc_in();
      rst_n = 1'b1;
      smp();
      chk("t6_no_pop_first_cycle", 64'(axi4s_mstr_rd), 64'd0);
      smp();
      chk("t6_pop_second_cycle", 64'(axi4s_mstr_rd), 64'd1);
      repeat (4) smp();
      chk("t6_word_cnt", 64'(osf_ob_word_cnt), 64'd1);
      chk("t6_frm_cnt", 64'(osf_ob_frm_cnt), 64'd1);

      chk("scoreboard_empty", 64'(expq.size()), 64'd0);
      chk("source_empty", 64'(src.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
